// File: rtl/sprite_draw.sv
// sprite_draw: blits one SPR_W x SPR_H sprite into the 160x120 frame buffer
// through the vga_adapter plot port. Draw mode skips transparent sprite
// pixels; erase mode repaints the footprint from the background ROM.
// Pixels landing off-screen are clipped (their slot is still consumed).
//
// Handshake: start is sampled only while busy=0 (IDLE). A start seen in IDLE
// latches pos_x/pos_y/erase and begins a blit; start while busy=1 is dropped,
// never queued. done pulses for exactly one cycle at the end of a blit, and
// busy falls in the following cycle, when a new start can be accepted.
module sprite_draw #(
  parameter int         SPR_W  = 8,
  parameter int         SPR_H  = 8,
  parameter int         SPR_AW = 6,
  parameter logic [2:0] TRANSP = 3'b101
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              erase,
  input  logic [7:0]        pos_x,
  input  logic [6:0]        pos_y,
  output logic [SPR_AW-1:0] spr_addr,
  input  logic [2:0]        spr_data,
  output logic [14:0]       bg_addr,
  input  logic [2:0]        bg_data,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_PLOT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0] I_LAST = 8'(SPR_W - 1);
  localparam logic [6:0] J_LAST = 7'(SPR_H - 1);

  state_t     state, state_n;
  logic [7:0] px;
  logic [6:0] py;
  logic       er;
  logic [7:0] i;
  logic [6:0] j;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic [14:0] y15, x15;
  logic       onscreen;

  // Screen coordinates of the current pixel, kept wide so the clip test
  // sees positions past the right/bottom edges instead of wrapped ones.
  assign sum_x    = {1'b0, px} + {1'b0, i};
  assign sum_y    = {1'b0, py} + {1'b0, j};
  assign onscreen = (sum_x <= 9'd159) && (sum_y <= 8'd119);

  // ROM addresses: combinational from latched position and counters, so
  // they are stable from ADDR through PLOT of each pixel.
  assign spr_addr = SPR_AW'(32'(j) * 32'(SPR_W) + 32'(i));
  assign y15      = {7'b0, sum_y};
  assign x15      = {6'b0, sum_x};
  assign bg_addr  = (y15 << 7) + (y15 << 5) + x15;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state logic: three cycles per pixel, row-major, i fastest.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_ADDR;
      S_ADDR: state_n = S_WAIT;
      S_WAIT: state_n = S_PLOT;
      S_PLOT: begin
        if ((i < I_LAST) || (j < J_LAST)) state_n = S_ADDR;
        else                              state_n = S_DONE;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: latch the request, register pixel outputs, step counters.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      px     <= '0;
      py     <= '0;
      er     <= 1'b0;
      i      <= '0;
      j      <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            px <= pos_x;
            py <= pos_y;
            er <= erase;
            i  <= '0;
            j  <= '0;
          end
        end
        S_WAIT: begin
          // ROM data for the address held since ADDR is valid now.
          x      <= sum_x[7:0];
          y      <= sum_y[6:0];
          colour <= er ? bg_data : spr_data;
          plot   <= onscreen && (er || (spr_data != TRANSP));
        end
        S_PLOT: begin
          plot <= 1'b0;
          if (i < I_LAST) begin
            i <= i + 8'd1;
          end else if (j < J_LAST) begin
            i <= '0;
            j <= j + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw: ROM models, per-scenario tasks, summary.
module tb_sprite_draw;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        erase = 1'b0;
  logic [7:0]  pos_x = '0;
  logic [6:0]  pos_y = '0;
  logic [5:0]  spr_addr;
  logic [2:0]  spr_data = '0;
  logic [14:0] bg_addr;
  logic [2:0]  bg_data = '0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Captured plots packed as {cycle[7:0], x[7:0], y[6:0], colour[2:0]}.
  logic [25:0] act_q[$];
  logic [25:0] exp_q[$];
  logic [14:0] bg_at [0:255];
  int          done_k, done_n, idle_k;
  logic [2:0]  spr_rom [0:63];

  sprite_draw dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (start),
    .erase    (erase),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .spr_addr (spr_addr),
    .spr_data (spr_data),
    .bg_addr  (bg_addr),
    .bg_data  (bg_data),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous ROMs, one-cycle latency; background data = low address bits.
  always @(posedge CLOCK_50) begin
    spr_data <= spr_rom[spr_addr];
    bg_data  <= bg_addr[2:0];
  end

  task automatic fill_rom(input logic [2:0] v0, input logic [2:0] rest);
    for (int a = 0; a < 64; a++) spr_rom[a] = (a == 0) ? v0 : rest;
  endtask

  // Driver: start one blit, then watch 200 cycles. Cycle k is the k-th
  // cycle after the edge that samples start. Inputs are scrambled right
  // after the start edge; optionally a second start is pulsed at cycle 100.
  task automatic run_blit(input logic [7:0] px, input logic [6:0] py,
                          input logic er, input bit pulse);
    act_q.delete();
    done_k = -1;
    done_n = 0;
    idle_k = -1;
    @(negedge CLOCK_50);
    start = 1'b1; pos_x = px; pos_y = py; erase = er;
    for (int k = 1; k <= 200; k++) begin
      @(negedge CLOCK_50);
      bg_at[k] = bg_addr;
      if (plot) act_q.push_back({8'(k), x, y, colour});
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (!busy && idle_k < 0) idle_k = k;
      if (k == 1) begin
        start = 1'b0; pos_x = 8'd99; pos_y = 7'd99; erase = ~er;
      end
      if (pulse && k == 100) begin
        start = 1'b1; pos_x = 8'd50; pos_y = 7'd50;
      end
      if (pulse && k == 101) start = 1'b0;
    end
    erase = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if ({plot, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: plot/busy/done=%b want 000", {plot, busy, done});
    end
    checks++;
    if ({x, y, colour} !== 18'd0) begin
      errors++; $display("FAIL reset_pix: x=%0d y=%0d colour=%0d want 0 0 0", x, y, colour);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_state: state=%0d want 0", dbg_state);
    end
    checks++;
    if (spr_addr !== 6'd0) begin
      errors++; $display("FAIL reset_ij: spr_addr=%0d want 0", spr_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_draw;
    fill_rom(3'b010, 3'b010);
    run_blit(8'd10, 7'd20, 1'b0, 1'b0);
    exp_q.delete();
    for (int n = 0; n < 64; n++)
      exp_q.push_back({8'(3 + 3 * n), 8'(10 + n % 8), 7'(20 + n / 8), 3'b010});
    checks++;
    if (act_q.size() != 64) begin
      errors++; $display("FAIL draw_count: got %0d want 64", act_q.size());
    end
    for (int n = 0; n < act_q.size() && n < exp_q.size(); n++) begin
      checks++;
      if (act_q[n] !== exp_q[n]) begin
        errors++; $display("FAIL draw_pix[%0d]: got %h want %h", n, act_q[n], exp_q[n]);
      end
    end
    checks++;
    if (done_k != 193 || done_n != 1) begin
      errors++; $display("FAIL draw_done: cycle=%0d n=%0d want 193 1", done_k, done_n);
    end
    checks++;
    if (idle_k != 194) begin
      errors++; $display("FAIL draw_busy: low at %0d want 194", idle_k);
    end
  endtask

  task automatic test_transparency;
    fill_rom(3'b101, 3'b001);
    run_blit(8'd30, 7'd40, 1'b0, 1'b0);
    exp_q.delete();
    for (int p = 1; p < 64; p++)
      exp_q.push_back({8'(3 + 3 * p), 8'(30 + p % 8), 7'(40 + p / 8), 3'b001});
    checks++;
    if (act_q.size() != 63) begin
      errors++; $display("FAIL transp_count: got %0d want 63", act_q.size());
    end
    for (int n = 0; n < act_q.size() && n < exp_q.size(); n++) begin
      checks++;
      if (act_q[n] !== exp_q[n]) begin
        errors++; $display("FAIL transp_pix[%0d]: got %h want %h", n, act_q[n], exp_q[n]);
      end
    end
    checks++;
    if (done_k != 193) begin
      errors++; $display("FAIL transp_done: cycle=%0d want 193", done_k);
    end
  endtask

  task automatic test_clipping;
    fill_rom(3'b011, 3'b011);
    run_blit(8'd156, 7'd116, 1'b0, 1'b0);
    exp_q.delete();
    for (int n = 0; n < 16; n++) begin
      int i, j;
      i = n % 4;
      j = n / 4;
      exp_q.push_back({8'(3 + 3 * (j * 8 + i)), 8'(156 + i), 7'(116 + j), 3'b011});
    end
    checks++;
    if (act_q.size() != 16) begin
      errors++; $display("FAIL clip_count: got %0d want 16", act_q.size());
    end
    for (int n = 0; n < act_q.size() && n < exp_q.size(); n++) begin
      checks++;
      if (act_q[n] !== exp_q[n]) begin
        errors++; $display("FAIL clip_pix[%0d]: got %h want %h", n, act_q[n], exp_q[n]);
      end
    end
    checks++;
    if (done_k != 193) begin
      errors++; $display("FAIL clip_done: cycle=%0d want 193", done_k);
    end
  endtask

  task automatic test_erase;
    // Sprite ROM is all transparent: erase must still paint every pixel.
    fill_rom(3'b101, 3'b101);
    run_blit(8'd0, 7'd1, 1'b1, 1'b0);
    exp_q.delete();
    for (int n = 0; n < 64; n++) begin
      int i, j, a;
      logic [14:0] a15;
      i = n % 8;
      j = n / 8;
      a = 160 * (1 + j) + i;
      a15 = a[14:0];
      exp_q.push_back({8'(3 + 3 * n), 8'(i), 7'(1 + j), a15[2:0]});
    end
    checks++;
    if (bg_at[2] !== 15'd160) begin
      errors++; $display("FAIL erase_addr_first: got %0d want 160", bg_at[2]);
    end
    checks++;
    if (bg_at[191] !== 15'd1287) begin
      errors++; $display("FAIL erase_addr_last: got %0d want 1287", bg_at[191]);
    end
    checks++;
    if (act_q.size() != 64) begin
      errors++; $display("FAIL erase_count: got %0d want 64", act_q.size());
    end
    for (int n = 0; n < act_q.size() && n < exp_q.size(); n++) begin
      checks++;
      if (act_q[n] !== exp_q[n]) begin
        errors++; $display("FAIL erase_pix[%0d]: got %h want %h", n, act_q[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_busy_reject;
    fill_rom(3'b010, 3'b010);
    run_blit(8'd10, 7'd20, 1'b0, 1'b1);
    exp_q.delete();
    for (int n = 0; n < 64; n++)
      exp_q.push_back({8'(3 + 3 * n), 8'(10 + n % 8), 7'(20 + n / 8), 3'b010});
    checks++;
    if (act_q.size() != 64) begin
      errors++; $display("FAIL busy_count: got %0d want 64", act_q.size());
    end
    for (int n = 0; n < act_q.size() && n < exp_q.size(); n++) begin
      checks++;
      if (act_q[n] !== exp_q[n]) begin
        errors++; $display("FAIL busy_pix[%0d]: got %h want %h", n, act_q[n], exp_q[n]);
      end
    end
    checks++;
    if (done_n != 1 || done_k != 193) begin
      errors++; $display("FAIL busy_done: n=%0d cycle=%0d want 1 193", done_n, done_k);
    end
  endtask

  task automatic test_reset_mid;
    fill_rom(3'b010, 3'b010);
    @(negedge CLOCK_50);
    start = 1'b1; pos_x = 8'd10; pos_y = 7'd20; erase = 1'b0;
    // Pixel (3,2) is pixel 19, whose PLOT is cycle 3+3*19 = 60.
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLOCK_50);
      if (k == 1) start = 1'b0;
    end
    checks++;
    if ({plot, x, y} !== {1'b1, 8'd13, 7'd22}) begin
      errors++; $display("FAIL mid_pre: plot=%b x=%0d y=%0d want 1 13 22", plot, x, y);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({plot, busy, done, dbg_state} !== 6'b000_000) begin
      errors++; $display("FAIL mid_abort: plot/busy/done=%b state=%0d want 000 0",
                         {plot, busy, done}, dbg_state);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      checks++;
      if ({plot, busy, done} !== 3'b000) begin
        errors++; $display("FAIL mid_hold[%0d]: plot/busy/done=%b want 000", k, {plot, busy, done});
      end
    end
    reset = 1'b0;
    run_blit(8'd40, 7'd30, 1'b0, 1'b0);
    checks++;
    if (act_q.size() != 64) begin
      errors++; $display("FAIL mid_restart_count: got %0d want 64", act_q.size());
    end
    if (act_q.size() > 0) begin
      checks++;
      if (act_q[0] !== {8'd3, 8'd40, 7'd30, 3'b010}) begin
        errors++; $display("FAIL mid_restart_first: got %h want %h", act_q[0],
                           {8'd3, 8'd40, 7'd30, 3'b010});
      end
    end
    checks++;
    if (done_k != 193) begin
      errors++; $display("FAIL mid_restart_done: cycle=%0d want 193", done_k);
    end
  endtask

  initial begin
    fill_rom(3'b000, 3'b000);
    test_reset();
    test_draw();
    test_transparency();
    test_clipping();
    test_erase();
    test_busy_reject();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_draw.md
# sprite_draw

Pixel-writer stage that blits one fixed-size sprite from a sprite ROM into the 160x120 frame buffer through the `vga_adapter` plot port (`x`, `y`, `colour`, `plot`). It sits beside the background drawer, downstream of game logic that supplies a sprite position. It supports a draw mode, which skips transparent pixels, and an erase mode, which repaints the sprite footprint from the background ROM. Pixels that fall outside the screen are clipped.

## Interface
- `SPR_W`, 8, sprite width in pixels
- `SPR_H`, 8, sprite height in pixels
- `SPR_AW`, 6, sprite ROM address width; must satisfy `SPR_W*SPR_H <= 2**SPR_AW`
- `TRANSP`, 3'b101, colour code treated as transparent in draw mode
- `CLOCK_50` in 1: the single clock; all logic on its rising edge
- `reset` in 1: asynchronous, active-high; forces IDLE and the reset values below
- `start` in 1: request to draw or erase; sampled only in IDLE
- `erase` in 1: mode select, sampled with `start` (1 = erase, 0 = draw)
- `pos_x` in 8: sprite top-left x, 0..255; sampled with `start`
- `pos_y` in 7: sprite top-left y, 0..127; sampled with `start`
- `spr_addr` out SPR_AW: sprite ROM address = `j*SPR_W + i`
- `spr_data` in 3: sprite ROM data; synchronous ROM, 1-cycle read latency
- `bg_addr` out 15: background ROM address = `160*(pos_y+j) + (pos_x+i)`
- `bg_data` in 3: background ROM data; 1-cycle read latency
- `x` out 8, `y` out 7, `colour` out 3, `plot` out 1: vga_adapter pixel write
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when a blit finishes

## Operation
- Reset values: state IDLE; `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0; `i`=`j`=0.
- States: IDLE, ADDR, WAIT, PLOT, DONE.
- IDLE -> ADDR when `start`=1.
  - On that edge, latch `pos_x`, `pos_y` and `erase`, and clear `i` and `j`.
- ADDR -> WAIT, unconditional.
  - `spr_addr` and `bg_addr` are combinational from the latched position and the counters, and are stable through ADDR and WAIT.
- WAIT -> PLOT, unconditional. At the edge leaving WAIT, register the pixel outputs:
  - `x` <= low 8 bits of `pos_x+i`; `y` <= low 7 bits of `pos_y+j`.
  - `colour` <= `bg_data` in erase mode, otherwise `spr_data`.
  - `plot` <= `onscreen && (erase || spr_data != TRANSP)`.
  - `onscreen` = (9-bit `pos_x+i` <= 159) && (8-bit `pos_y+j` <= 119).
- PLOT: `plot` is high for at most this one cycle.
  - At the exit edge, `plot` <= 0.
  - If `i < SPR_W-1`: `i++` -> ADDR.
  - Else if `j < SPR_H-1`: `i`=0, `j++` -> ADDR.
  - Else -> DONE.
- DONE: `done`=1 for this cycle only -> IDLE.
- Pixel order: row-major, `i` fastest.
- Arithmetic: compute `bg_addr` as `(y<<7)+(y<<5)+x` in 15 bits.
  - When the pixel is off-screen, `bg_addr` is don't-care and no plot is issued.
- `start` while `busy` is ignored; no queuing.
- `pos_x`, `pos_y` and `erase` changing mid-blit have no effect.
- `reset` mid-blit aborts immediately: `plot` drops asynchronously and no `done` is issued. The partially drawn sprite stays in the frame buffer.

## Timing
- Latency: the first PLOT cycle is the 3rd cycle after the edge that samples `start`.
- Each pixel takes 3 cycles (ADDR, WAIT, PLOT).
- `done` is high in cycle `3*SPR_W*SPR_H + 1` after the start edge: 193 cycles for 8x8.
- A new `start` is accepted at the edge ending DONE+1 (the first IDLE cycle), giving 194 cycles minimum between starts.
- `x`, `y` and `colour` are registered and stable for the whole cycle in which `plot`=1.
- The ROMs must present data one edge after the address is stable.

## Test plan
- Reset mid-blit:
  - Stimulus: assert `reset` during PLOT of pixel (3,2).
  - Required: `plot`, `busy` and `done` go to 0 immediately and stay 0; state is IDLE.
  - Required: the next `start` blits from (0,0).
- Draw on-screen:
  - Stimulus: `pos`=(10,20), `erase`=0, ROM all 3'b010.
  - Required: 64 plots covering x 10..17, y 20..27 in row-major order.
  - Required: first plot 3 cycles after start; `done` at cycle 193; `busy` low at cycle 194.
- Transparency:
  - Stimulus: ROM word 0 = 3'b101, all others 3'b001.
  - Required: no plot at (pos_x,pos_y) but the 3-cycle slot is still consumed; 63 plots; `done` still at cycle 193.
- Clipping:
  - Stimulus: `pos`=(156,116).
  - Required: only x 156..159 and y 116..119 are plotted (16 plots).
  - Required: no wrapped pixels at x 0..3 or y 0..3.
- Erase:
  - Stimulus: `pos`=(0,1), `erase`=1, bg ROM data = low 3 bits of address.
  - Required: `bg_addr` for pixel (0,1) = 160, `colour`=3'b000.
  - Required: `bg_addr` for pixel (7,8) = 1287, `colour`=3'b111.
  - Required: all 64 pixels plotted.
- Busy rejection:
  - Stimulus: pulse `start` with `pos`=(50,50) at cycle 100 of a blit at (10,20).
  - Required: it is ignored; plots stay within the first sprite; exactly one `done`.
